ring_slide_endpoint: RTL
========================

RING_SLIDE_ENDPOINT -- requirements
Module: ring_slide_endpoint

Interface
REQ-001 SHALL have parameter DataWidth, default 64, width of one ring word (elen).
REQ-002 SHALL have parameter CntWidth, default 16, width of the transfer length counter.
REQ-003 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (reset); one clock, reset asynchronous active-low.
REQ-004 SHALL have cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-005 SHALL have cmd_dir_i in 1 (0 slidedown/left, 1 slideup/right), cmd_bypass_i in 1, cmd_len_i in CntWidth (words to send and receive).
REQ-006 SHALL have tx_data_i in DataWidth, tx_valid_i in 1, tx_ready_o out 1: local words to transmit.
REQ-007 SHALL have rx_data_o out DataWidth, rx_valid_o out 1, rx_ready_i in 1: words received from the ring.
REQ-008 SHALL have ring_data_o out DataWidth, ring_valid_o out 1, ring_ready_i in 1: to router sldu input.
REQ-009 SHALL have ring_data_i in DataWidth, ring_valid_i in 1, ring_ready_o out 1: from router sldu output.
REQ-010 SHALL have sldu_dir_o out 1, sldu_bypass_o out 1, sldu_config_valid_o out 1: router configuration.
REQ-011 SHALL have busy_o out 1 (state != IDLE) and done_o out 1 (one-cycle completion pulse).

Function
REQ-012 SHALL implement FSM states IDLE, CONFIG, XFER, DONE.
REQ-013 IDLE: cmd_ready_o=1; on cmd_valid_i, latch dir, bypass, len; go to CONFIG.
REQ-014 CONFIG: sldu_config_valid_o=1 for exactly one cycle; sldu_dir_o/sldu_bypass_o hold the latched values from CONFIG until the next command is accepted.
REQ-015 CONFIG exit: if bypass=1 or len=0, go to DONE; else go to XFER.
REQ-016 TX path SHALL use a single output register: ring_valid_o/ring_data_o are registered; a word leaves on ring_valid_o && ring_ready_i.
REQ-017 tx_ready_o = (state==XFER) && tx_cnt<len && (!ring_valid_o || ring_ready_i); tx_cnt increments on each tx_valid_i && tx_ready_o.
REQ-018 ring_data_o SHALL remain stable while ring_valid_o && !ring_ready_i.
REQ-019 RX path SHALL use a 2-entry FIFO; ring_ready_o = (state==XFER) && FIFO not full && rx_cnt<len; rx_cnt increments on each ring_valid_i && ring_ready_o.
REQ-020 rx_valid_o = FIFO not empty; rx_data_o = FIFO head; pop on rx_valid_i... pop on rx_valid_o && rx_ready_i; simultaneous push and pop on a full FIFO SHALL NOT be allowed (ring_ready_o already 0 when full).
REQ-021 Word order SHALL be preserved in both directions; no word dropped or duplicated.
REQ-022 XFER exit to DONE SHALL occur the cycle after tx_cnt==len, rx_cnt==len, ring_valid_o==0 and FIFO empty all hold.
REQ-023 DONE: done_o=1 for one cycle; then IDLE.
REQ-024 cmd_ready_o SHALL be 0 in all states except IDLE; tx_ready_o and ring_ready_o SHALL be 0 outside XFER.
REQ-025 Counters SHALL be CntWidth bits, reset to 0 on each command acceptance; no wrap (max len 2^CntWidth-1).
REQ-026 Latency: cmd accept -> config pulse 1 cycle; tx word accepted -> ring_valid_o next cycle; ring word accepted -> rx_valid_o next cycle.

Reset
REQ-027 On rst_ni=0, asynchronously: state IDLE, counters 0, FIFO empty, ring_valid_o=0, rx_valid_o=0, sldu_config_valid_o=0, sldu_dir_o=0, sldu_bypass_o=0, done_o=0, busy_o=0; data outputs 0.
REQ-028 Reset mid-transfer SHALL discard all buffered words and in-flight counts; no done_o pulse.

Verification
REQ-029 Cmd dir=1, len=4, tx 0xA0..0xA3, ring loopback with ready always 1 -> config pulse dir=1 bypass=0, ring_data_o sequence A0..A3, rx_data_o A0..A3, one done_o pulse.
REQ-030 Cmd bypass=1, len=8 -> config pulse bypass=1, no tx_ready_o/ring_ready_o assertion, done_o two cycles after cmd accept.
REQ-031 Cmd len=0 -> config pulse then done_o; no data handshakes.
REQ-032 len=6, ring_ready_i toggling 1010..., rx_ready_i low 5 cycles -> ring_data_o stable under stall, ring_ready_o drops after 2 buffered words, all 6 words delivered in order, done only after FIFO drains.
REQ-033 rst_ni asserted after 3 of len=8 words -> all outputs at reset values immediately; new cmd len=2 completes normally.
REQ-034 cmd_valid_i held high during XFER -> cmd_ready_o=0 until IDLE; second command accepted the cycle after done_o.

Source files
------------

// File: rtl/ring_slide_endpoint.sv
// Slide-unit ring endpoint: configures the router slide direction, streams local
// words onto the ring through one output register and collects ring words in a 2-deep FIFO.
module ring_slide_endpoint #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // command
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_dir_i,
  input  logic                 cmd_bypass_i,
  input  logic [CntWidth-1:0]  cmd_len_i,
  // local transmit words
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  // words received from the ring
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  // to router slide input
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  // from router slide output
  input  logic [DataWidth-1:0] ring_data_i,
  input  logic                 ring_valid_i,
  output logic                 ring_ready_o,
  // router configuration
  output logic                 sldu_dir_o,
  output logic                 sldu_bypass_o,
  output logic                 sldu_config_valid_o,
  // status
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           dbg_state_o
);

  // Every channel is valid/ready: a word moves on a cycle where both are high,
  // and a producer that raised valid holds valid and data unchanged until then.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    XFER   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic                 dir_q;
  logic                 bypass_q;
  logic [CntWidth-1:0]  len_q;
  logic [CntWidth-1:0]  tx_cnt;
  logic [CntWidth-1:0]  rx_cnt;

  logic [DataWidth-1:0] ring_data_q;
  logic                 ring_valid_q;

  logic [DataWidth-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 in_xfer;
  logic                 cmd_fire;
  logic                 tx_fire;
  logic                 out_fire;
  logic                 in_fire;
  logic                 rx_fire;
  logic                 xfer_complete;

  assign in_xfer    = (state == XFER);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);

  assign tx_ready_o   = in_xfer && (tx_cnt < len_q) && (!ring_valid_q || ring_ready_i);
  assign ring_ready_o = in_xfer && !fifo_full && (rx_cnt < len_q);

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign tx_fire  = tx_valid_i && tx_ready_o;
  assign out_fire = ring_valid_q && ring_ready_i;
  assign in_fire  = ring_valid_i && ring_ready_o;
  assign rx_fire  = rx_valid_o && rx_ready_i;

  // All words sent and received, and nothing left buffered in either direction.
  assign xfer_complete = (tx_cnt == len_q) && (rx_cnt == len_q) &&
                         !ring_valid_q && fifo_empty;

  assign ring_data_o   = ring_data_q;
  assign ring_valid_o  = ring_valid_q;
  assign rx_data_o     = fifo_mem[rd_ptr];
  assign rx_valid_o    = !fifo_empty;
  assign sldu_dir_o    = dir_q;
  assign sldu_bypass_o = bypass_q;
  assign busy_o        = (state != IDLE);
  assign dbg_state_o   = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next          = state;
    cmd_ready_o         = 1'b0;
    sldu_config_valid_o = 1'b0;
    done_o              = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          state_next = CONFIG;
        end
      end
      CONFIG: begin
        sldu_config_valid_o = 1'b1;
        if (bypass_q || (len_q == '0)) begin
          state_next = DONE;
        end else begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (xfer_complete) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command fields stay visible on the router config outputs until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q    <= 1'b0;
      bypass_q <= 1'b0;
      len_q    <= '0;
    end else if (cmd_fire) begin
      dir_q    <= cmd_dir_i;
      bypass_q <= cmd_bypass_i;
      len_q    <= cmd_len_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else if (cmd_fire) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_fire) begin
        tx_cnt <= tx_cnt + CntWidth'(1);
      end
      if (in_fire) begin
        rx_cnt <= rx_cnt + CntWidth'(1);
      end
    end
  end

  // Single output register: refilled in the same cycle it drains, held under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_data_q  <= '0;
      ring_valid_q <= 1'b0;
    end else if (tx_fire) begin
      ring_data_q  <= tx_data_i;
      ring_valid_q <= 1'b1;
    end else if (out_fire) begin
      ring_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (in_fire) begin
        fifo_mem[wr_ptr] <= ring_data_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (rx_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({in_fire, rx_fire})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
